data_memory_dp: RTL and testbench
=================================

DATA_MEMORY_DP -- requirements
Module: data_memory_dp

Interface
REQ-001 Parameter DATA_W, default 64, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 10, address width; depth DEPTH = 2**ADDR_W words.
REQ-003 Parameter RDW_MODE, default 1, read-during-write result: 1 = new (merged) data, 0 = old data.
REQ-004 Derived BE_W = DATA_W/8, the number of byte lanes.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_addr  input  ADDR_W  write address.
REQ-009 wr_data  input  DATA_W  write data.
REQ-010 wr_be  input  BE_W  byte enables; bit i gates wr_data[8i+7:8i].
REQ-011 rd_en  input  1  read request.
REQ-012 rd_addr  input  ADDR_W  read address.
REQ-013 rd_data  output  DATA_W  registered read data.
REQ-014 rd_valid  output  1  rd_data holds the result of the previous cycle's read.
REQ-015 collision  output  1  the previous cycle's read hit the same-cycle write address.
REQ-016 init_busy  output  1  the array is being cleared; all requests are ignored.

Function
REQ-017 The FSM SHALL have two states, INIT and READY; reset SHALL force INIT with the clear counter at 0.
REQ-018 Each INIT cycle SHALL write all-zeros to cell[counter] and increment the counter.
REQ-019 When counter == DEPTH-1, the FSM SHALL write that cell and move to READY on the same edge, so INIT lasts exactly DEPTH cycles.
REQ-020 init_busy SHALL equal 1 exactly while in INIT.
REQ-021 In INIT, wr_en and rd_en SHALL be ignored: no user write, rd_valid=0, collision=0, and rd_data unchanged.
REQ-022 In READY, with wr_en=1 at an edge, each lane i with wr_be[i]=1 SHALL take the new byte; lanes with wr_be[i]=0 SHALL be unchanged.
REQ-023 wr_en=1 with wr_be=0 SHALL leave the array unchanged.
REQ-024 In READY, with rd_en=1 at edge N, rd_data SHALL present cell[rd_addr] and rd_valid=1 after edge N (read latency 1 cycle).
REQ-025 If rd_en=0 at an edge, rd_valid SHALL be 0 after it and rd_data SHALL hold its last value.
REQ-026 Back-to-back reads SHALL be accepted every cycle, with no bubbles.
REQ-027 If rd_en, wr_en and rd_addr==wr_addr at the same edge, collision SHALL be 1 for the following cycle only; otherwise collision SHALL be 0.
REQ-028 With RDW_MODE=1, the collision read SHALL return enabled lanes from wr_data and the other lanes from the old cell.
REQ-029 With RDW_MODE=0, the collision read SHALL return the pre-write cell contents.
REQ-030 The write SHALL always complete regardless of a read collision.
REQ-031 Addresses SHALL be taken modulo DEPTH; no out-of-range condition exists.

Reset
REQ-032 Asserting rst SHALL immediately set rd_data=0, rd_valid=0, collision=0, init_busy=1, state INIT and counter 0.
REQ-033 Reset asserted mid-INIT or mid-READY SHALL restart the clear from address 0 after release; a partially cleared array is never exposed.
REQ-034 The first INIT clear write SHALL occur at the first rising clk edge after rst deasserts.

Verification
REQ-035 Release reset, hold rd_en=1 -> init_busy=1 for 1024 cycles, rd_valid=0 throughout; then reading every address returns 0.
REQ-036 Write 0x0123456789ABCDEF to address 5 with wr_be=0xFF, then read address 5 -> next-cycle rd_data=0x0123456789ABCDEF, rd_valid=1, collision=0.
REQ-037 Address 7 holds 0x1111111111111111; write 0xFFFFFFFFFFFFFFFF with wr_be=0x0F -> a later read returns 0x11111111FFFFFFFF.
REQ-038 Address 3 holds 0xAA..AA; same-edge read and write of 0x55..55 (wr_be=0xFF) -> collision=1; rd_data=0x55..55 (RDW_MODE=1) or 0xAA..AA (RDW_MODE=0); a later read returns 0x55..55.
REQ-039 Assert rst at clear counter 500, release -> init_busy stays 1 for a further 1024 cycles and address 900, previously written 0x1234, reads 0.
REQ-040 Issue reads on 8 consecutive cycles to addresses 0..7 -> rd_valid=1 for 8 consecutive cycles, with data in order.

Source files
------------

// File: rtl/data_memory_dp.sv
// rtl/data_memory_dp.sv - dual-port byte-enabled data memory with power-on clear
//
// Purpose: one write port with byte enables, one registered read port and
// self-clearing of the whole array after every reset. Requests are accepted
// only once the clear sweep has finished.
//
// Parameters:
//   DATA_W   word width in bits, multiple of 8
//   ADDR_W   address width, DEPTH = 2**ADDR_W words
//   RDW_MODE read-during-write result: 1 = merged new data, 0 = old data
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data/wr_be   write request with per-byte enables
//   rd_en/rd_addr       read request
//   rd_data/rd_valid    registered read result, valid one cycle after rd_en
//   collision           previous read hit the same-cycle write address
//   init_busy           array clear in progress, requests ignored
module data_memory_dp #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 10,
    parameter int RDW_MODE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [DATA_W/8-1:0]  wr_be,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_valid,
    output logic                 collision,
    output logic                 init_busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [DATA_W-1:0]   wr_old;
    logic [DATA_W-1:0]   rd_old;
    logic [DATA_W-1:0]   wr_word;
    logic [DATA_W-1:0]   rd_merged;
    logic                hit;

    assign wr_old = mem[wr_addr];
    assign rd_old = mem[rd_addr];
    assign hit    = wr_en && rd_en && (rd_addr == wr_addr);

    // wr_word is the full word stored by a user write; rd_merged is what a
    // colliding read sees in new-data mode (same lane overlay on the read cell).
    always_comb begin
        wr_word   = wr_old;
        rd_merged = rd_old;
        for (int i = 0; i < BE_W; i++) begin
            if (wr_be[i]) begin
                wr_word[8*i +: 8]   = wr_data[8*i +: 8];
                rd_merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    // Clear sequencer: one cell per cycle; the last cell is written on the
    // same edge that enters READY, so INIT lasts exactly DEPTH cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            clr_cnt   <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    if (clr_cnt == '1) begin
                        state     <= READY;
                        init_busy <= 1'b0;
                        clr_cnt   <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                READY: begin
                    state <= READY;
                end
                default: begin
                    state     <= INIT;
                    clr_cnt   <= '0;
                    init_busy <= 1'b1;
                end
            endcase
        end
    end

    // Array storage has no reset of its own; the clear sweep zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[clr_cnt] <= '0;
            end else if (wr_en && (wr_be != '0)) begin
                mem[wr_addr] <= wr_word;
            end
        end
    end

    // Read port samples the array before this edge's write lands, so
    // rd_old is the pre-write contents on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            collision <= 1'b0;
        end else if (state == READY && rd_en) begin
            rd_valid  <= 1'b1;
            collision <= hit;
            rd_data   <= (hit && (RDW_MODE != 0)) ? rd_merged : rd_old;
        end else begin
            rd_valid  <= 1'b0;
            collision <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_memory_dp.sv
// tb/tb_data_memory_dp.sv - self-checking bench for data_memory_dp
module tb_data_memory_dp;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [7:0]        wr_be;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;

    logic [DATA_W-1:0] rd_data,  rd_data0;
    logic              rd_valid, rd_valid0;
    logic              collision, collision0;
    logic              init_busy, init_busy0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] exp_new;
    logic [DATA_W-1:0] exp_old;

    data_memory_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RDW_MODE(1)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .collision(collision),
        .init_busy(init_busy)
    );

    data_memory_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .collision(collision0),
        .init_busy(init_busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [7:0] be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < 8; i++)
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // Runs the clear phase with random ignored traffic and counts its length.
    task automatic wait_init(input string tag);
        int n;
        int bad;
        n = 0;
        bad = 0;
        while (init_busy && n < 3000) begin
            if (rd_valid !== 1'b0 || collision !== 1'b0 || rd_data !== '0 ||
                rd_valid0 !== 1'b0 || rd_data0 !== '0)
                bad++;
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = ADDR_W'($urandom);
            wr_data = {$urandom, $urandom};
            wr_be   = 8'hFF;
            rd_en   = 1'b1;
            rd_addr = ADDR_W'($urandom);
            step();
            n++;
        end
        idle_inputs();
        total_cnt++;
        if (n !== DEPTH) $display("FAIL %s init_len: got %0d cycles want %0d", tag, n, DEPTH);
        else pass_cnt++;
        total_cnt++;
        if (bad !== 0) $display("FAIL %s init_quiet: %0d cycles with outputs active want 0", tag, bad);
        else pass_cnt++;
        clear_model();
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [7:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        step();
        ref_mem[a] = merge(ref_mem[a], d, be);
        wr_en = 1'b0; wr_be = '0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        total_cnt++;
        if (rd_data !== '0 || rd_valid !== 1'b0 || collision !== 1'b0 || init_busy !== 1'b1)
            $display("FAIL reset_state: rd_data=%h rd_valid=%b collision=%b init_busy=%b want 0/0/0/1",
                     rd_data, rd_valid, collision, init_busy);
        else pass_cnt++;
        step();
        rst = 1'b0;
        wait_init("first");
    endtask

    task automatic test_read_all();
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 1'b1; rd_addr = ADDR_W'(i);
            step();
            if (rd_valid !== 1'b1 || rd_data !== ref_mem[i]) bad++;
        end
        rd_en = 1'b0;
        total_cnt++;
        if (bad !== 0) $display("FAIL read_all_zero: %0d bad reads want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_full_write();
        do_write(10'd5, 64'h0123456789ABCDEF, 8'hFF);
        do_read(10'd5);
        total_cnt++;
        if (rd_data !== 64'h0123456789ABCDEF || rd_valid !== 1'b1 || collision !== 1'b0)
            $display("FAIL full_write: rd_data=%h v=%b c=%b want 0123456789abcdef/1/0",
                     rd_data, rd_valid, collision);
        else pass_cnt++;
        step();
        total_cnt++;
        if (rd_valid !== 1'b0 || rd_data !== 64'h0123456789ABCDEF)
            $display("FAIL idle_hold: rd_data=%h v=%b want 0123456789abcdef/0", rd_data, rd_valid);
        else pass_cnt++;
    endtask

    task automatic test_byte_enable();
        do_write(10'd7, 64'h1111111111111111, 8'hFF);
        do_write(10'd7, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        do_write(10'd7, 64'h2222222222222222, 8'h00);
        step();
        do_read(10'd7);
        total_cnt++;
        if (rd_data !== 64'h11111111FFFFFFFF || rd_valid !== 1'b1)
            $display("FAIL byte_enable: rd_data=%h v=%b want 11111111ffffffff/1", rd_data, rd_valid);
        else pass_cnt++;
    endtask

    task automatic test_collision();
        do_write(10'd3, {8{8'hAA}}, 8'hFF);
        wr_en = 1'b1; wr_addr = 10'd3; wr_data = {8{8'h55}}; wr_be = 8'hFF;
        rd_en = 1'b1; rd_addr = 10'd3;
        step();
        ref_mem[3] = {8{8'h55}};
        idle_inputs();
        total_cnt++;
        if (collision !== 1'b1 || rd_data !== {8{8'h55}} || rd_valid !== 1'b1)
            $display("FAIL collision_new: c=%b rd_data=%h want 1/%h", collision, rd_data, {8{8'h55}});
        else pass_cnt++;
        total_cnt++;
        if (collision0 !== 1'b1 || rd_data0 !== {8{8'hAA}})
            $display("FAIL collision_old: c=%b rd_data=%h want 1/%h", collision0, rd_data0, {8{8'hAA}});
        else pass_cnt++;
        step();
        total_cnt++;
        if (collision !== 1'b0 || collision0 !== 1'b0)
            $display("FAIL collision_clear: c=%b c0=%b want 0/0", collision, collision0);
        else pass_cnt++;
        do_read(10'd3);
        total_cnt++;
        if (rd_data !== {8{8'h55}} || rd_data0 !== {8{8'h55}})
            $display("FAIL collision_write_done: %h %h want %h", rd_data, rd_data0, {8{8'h55}});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int good;
        good = 0;
        for (int i = 0; i < 8; i++) ref_mem[i] = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) do_write(ADDR_W'(i), ref_mem[i], 8'hFF);
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1; rd_addr = ADDR_W'(i);
            step();
            if (rd_valid === 1'b1 && rd_data === ref_mem[i]) good++;
        end
        rd_en = 1'b0;
        total_cnt++;
        if (good !== 8) $display("FAIL back_to_back: %0d good reads want 8", good);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] want_new, want_old;
        logic want_v, want_c;
        int bad;
        bad = 0;
        want_new = rd_data;
        want_old = rd_data0;
        for (int k = 0; k < 1500; k++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = ADDR_W'($urandom_range(0, 15));
            wr_data = {$urandom, $urandom};
            wr_be   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            rd_en   = 1'($urandom_range(0, 3) != 0);
            rd_addr = ADDR_W'($urandom_range(0, 15));
            want_v  = rd_en;
            want_c  = rd_en && wr_en && (rd_addr == wr_addr);
            if (rd_en) begin
                want_old = ref_mem[rd_addr];
                want_new = want_c ? merge(ref_mem[rd_addr], wr_data, wr_be) : ref_mem[rd_addr];
            end
            if (wr_en) ref_mem[wr_addr] = merge(ref_mem[wr_addr], wr_data, wr_be);
            step();
            if (rd_valid !== want_v || collision !== want_c || rd_data !== want_new ||
                rd_valid0 !== want_v || collision0 !== want_c || rd_data0 !== want_old) begin
                if (bad < 5)
                    $display("FAIL random[%0d]: v=%b c=%b d=%h d0=%h want %b/%b/%h/%h",
                             k, rd_valid, collision, rd_data, rd_data0,
                             want_v, want_c, want_new, want_old);
                bad++;
            end
        end
        idle_inputs();
        total_cnt++;
        if (bad !== 0) $display("FAIL random_total: %0d bad cycles want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_reset_restart();
        do_write(10'd900, 64'h1234, 8'hFF);
        do_read(10'd900);
        total_cnt++;
        if (rd_data !== 64'h1234 || rd_valid !== 1'b1)
            $display("FAIL pre_reset_read: rd_data=%h v=%b want 1234/1", rd_data, rd_valid);
        else pass_cnt++;
        // reset while READY with a live read result
        rst = 1'b1;
        #1;
        total_cnt++;
        if (rd_data !== '0 || rd_valid !== 1'b0 || init_busy !== 1'b1)
            $display("FAIL ready_reset: rd_data=%h v=%b busy=%b want 0/0/1", rd_data, rd_valid, init_busy);
        else pass_cnt++;
        step();
        rst = 1'b0;
        // advance the clear counter to 500, then reset again
        for (int i = 0; i < 500; i++) begin
            rd_en = 1'b1; rd_addr = ADDR_W'(i);
            step();
        end
        rd_en = 1'b0;
        total_cnt++;
        if (init_busy !== 1'b1) $display("FAIL mid_init_busy: busy=%b want 1", init_busy);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (init_busy !== 1'b1 || rd_valid !== 1'b0 || collision !== 1'b0)
            $display("FAIL mid_init_reset: busy=%b v=%b c=%b want 1/0/0", init_busy, rd_valid, collision);
        else pass_cnt++;
        step();
        rst = 1'b0;
        wait_init("restart");
        do_read(10'd900);
        total_cnt++;
        if (rd_data !== '0 || rd_valid !== 1'b1)
            $display("FAIL cleared_900: rd_data=%h v=%b want 0/1", rd_data, rd_valid);
        else pass_cnt++;
        test_read_all();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        clear_model();
        test_reset();
        test_read_all();
        test_full_write();
        test_byte_enable();
        test_collision();
        test_back_to_back();
        test_random();
        test_reset_restart();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
